exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline, directly downstream of the ID/EX register; consumes its outputs.
- Generates the second operand (val2) and runs the 4-bit ALU command.
- Owns the architectural NZCV status register.
- Computes the branch target and registers results into an internal EX/MEM pipeline register that feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- MUL_CYCLES, 32, busy cycles of the iterative multiplier. Used only with MUL_EN.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- freeze  in  1  Memory-stage wait. Holds the EX/MEM register, the status register and the MUL FSM.
- wb_en, mem_read, mem_write, b, s, imm  in  1 each  Control from ID/EX.
- alu_command  in  4  ALU opcode.
- dest  in  4  Destination register index.
- status  in  4  NZCV captured at ID. Supplies carry-in, and C/V for logic ops.
- shift_operand  in  12  Instruction bits [11:0].
- signed_imm  in  24  Branch offset.
- pc, val_rn, val_rm  in  32 each  Operands; pc is instruction address + 4.
- branch_taken  out  1  Combinational; equals b.
- branch_addr  out  32  Combinational; pc + sign_extend(signed_imm) << 2.
- status_out  out  4  Registered NZCV, bit3 = N … bit0 = V.
- stall  out  1  Multiplier busy; upstream holds IF/ID/ID-EX. Always 0 without MUL_EN.
- wb_en_out, mem_read_out, mem_write_out  out  1 each  EX/MEM control.
- alu_res_out, val_rm_out  out  32 each  EX/MEM data.
- dest_out  out  4  EX/MEM destination.

Behaviour:
- Reset: every registered output and status_out go to 0. MUL FSM goes to IDLE. stall = 0.
- Latency: non-MUL ops are combinational in EX and visible at the EX/MEM outputs one clock after presentation.

val2 selection, in priority order:
- mem_read|mem_write: val2 = zero-extended shift_operand[11:0].
- imm = 1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
- Otherwise: val_rm shifted by shift_operand[11:7], type from shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - Amount 0 gives val_rm unchanged.
  - shift_operand[4] is ignored; register-specified shifts are not supported.

ALU commands:
- 0001 MOV: val2.
- 1001 MVN: ~val2.
- 0010 ADD: rn + val2.
- 0011 ADC: rn + val2 + C.
- 0100 SUB: rn − val2.
- 0101 SBC: rn − val2 − !C.
- 0110 AND.
- 0111 ORR.
- 1000 EOR.
- Any other code gives result 0.

Flags:
- N = res[31]; Z = (res == 0).
- Arithmetic ops: C from the 33-bit result; for SUB/SBC, C = no borrow. V = signed overflow.
- Logic/move ops: C and V pass through from the status input.

Status register:
- Loads the new NZCV at posedge when s = 1, freeze = 0, stall = 0.
- Otherwise holds.

EX/MEM register:
- Loads at posedge when freeze = 0 and stall = 0.
- When stall = 1 and freeze = 0, it loads a bubble: wb_en_out, mem_read_out, mem_write_out = 0; data unchanged.
- When freeze = 1, it holds everything.

Simultaneous events:
- rst dominates freeze and stall.
- freeze dominates stall: FSM counter and registers all hold.

Optional Feature:
MUL_EN
- Defined: alu_command 1010 is MUL, computed by an iterative shift-add unit on rn × val2; result is the low 32 bits.
  - FSM IDLE → BUSY on a MUL presented in IDLE with freeze = 0.
  - BUSY counts MUL_CYCLES, with stall = 1 throughout.
  - BUSY → DONE; in DONE, stall = 0 and the result is the ALU result. Its flags update N and Z only (C, V held). The result is registered at the DONE edge, then the FSM returns to IDLE.
  - Total residency is MUL_CYCLES + 1 cycles.
  - rst in any state returns the FSM to IDLE with the product discarded.
- Undefined: 1010 behaves as an undefined code (result 0). stall is tied 0. No FSM is instantiated.

Decomposition:
- Shared package arm_pkg:
  - ALU command constants.
  - Shift-type constants (LSL/LSR/ASR/ROR).
  - Status bit indices N = 3, Z = 2, C = 1, V = 0.
  - MUL FSM state enum.
- One natural sub-module, val2_gen: purely combinational immediate rotate and register shift. The ALU, status register, EX/MEM register and MUL FSM stay in exe_stage.

Test Plan:
- ADD with s = 1: rn = 0x7FFFFFFF, imm = 1, shift_operand = 0x001 → alu_res_out = 0x80000000 next cycle; status_out = 1001 (N, V).
- SUB (CMP) with s = 1: rn = 5, val_rm = 5, shift_operand LSL #0 → res 0; status_out = 0110 (Z, C). With s = 0, status_out stays unchanged.
- Immediate rotate: imm = 1, shift_operand = 0x4FF, MOV → 0xFF000000. Register ASR: val_rm = 0x80000000, shift_operand = {5'd4, 2'b10, 1'b0, 4'd0} → 0xF8000000.
- Branch: b = 1, pc = 0x100, signed_imm = 0xFFFFFE → branch_addr = 0xF8, branch_taken = 1 combinationally.
- freeze = 1 for 3 cycles with ADD presented → EX/MEM outputs and status hold; rst = 1 mid-freeze → all outputs 0 on the next edge.
- MUL_EN: MUL rn = 3, val2 = 0xFFFFFFFF, s = 1 → stall = 1 for exactly 32 cycles; wb_en_out = 0 during those cycles; then alu_res_out = 0xFFFFFFFD and N = 1. rst at busy cycle 10 → stall = 0 the next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared constants for the ARM execute stage.
//   - ALU command encodings
//   - shift-type encodings for register operands
//   - NZCV bit positions in the status nibble
//   - state encoding of the iterative multiplier FSM (used with MUL_EN)
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int unsigned ST_N = 3;
  localparam int unsigned ST_Z = 2;
  localparam int unsigned ST_C = 1;
  localparam int unsigned ST_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/val2_gen.sv
// val2_gen: second-operand generator (purely combinational).
// Ports:
//   mem_rw         in  load/store: operand is the 12-bit zero-extended offset
//   imm            in  operand is an 8-bit immediate rotated right by 2*[11:8]
//   shift_operand  in  instruction bits [11:0]
//   val_rm         in  register operand for immediate-amount shifts
//   val2           out selected second operand
module val2_gen
  import arm_pkg::*;
(
  input  logic        mem_rw,
  input  logic        imm,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  output logic [31:0] val2
);

  logic [4:0]  rot_amt_s;
  logic [4:0]  sh_amt_s;
  logic [63:0] imm_dbl_s;
  logic [63:0] rm_dbl_s;
  logic [31:0] rm_sh_s;
  logic        unused_s;

  // Rotations are done by shifting a doubled copy; the low half is the rotated word.
  assign rot_amt_s = {shift_operand[11:8], 1'b0};
  assign sh_amt_s  = shift_operand[11:7];
  assign imm_dbl_s = {2{{24'd0, shift_operand[7:0]}}} >> rot_amt_s;
  assign rm_dbl_s  = {val_rm, val_rm} >> sh_amt_s;

  // Register operand shifted by the immediate amount; amount 0 leaves it unchanged.
  always_comb begin
    case (shift_operand[6:5])
      SH_LSL:  rm_sh_s = val_rm << sh_amt_s;
      SH_LSR:  rm_sh_s = val_rm >> sh_amt_s;
      SH_ASR:  rm_sh_s = $signed(val_rm) >>> sh_amt_s;
      SH_ROR:  rm_sh_s = rm_dbl_s[31:0];
      default: rm_sh_s = val_rm;
    endcase
  end

  assign val2 = mem_rw ? {20'd0, shift_operand} :
                imm    ? imm_dbl_s[31:0] : rm_sh_s;

  // Bit 4 would select a register-specified shift, which this stage does not implement.
  assign unused_s = ^{shift_operand[4], imm_dbl_s[63:32], rm_dbl_s[63:32]};

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
// Builds val2, runs the ALU, owns the NZCV status register, computes the
// branch target and registers results into the EX/MEM register.
// Optional macro MUL_EN adds an iterative shift-add multiplier (command 1010)
// that stalls upstream while it works.
// Ports:
//   clk, rst (sync, active high), freeze (memory wait: hold EX/MEM, status, FSM)
//   ID/EX inputs: wb_en, mem_read, mem_write, b, s, imm, alu_command, dest,
//                 status, shift_operand, signed_imm, pc, val_rn, val_rm
//   branch_taken, branch_addr    combinational branch outputs
//   status_out                   registered NZCV
//   stall                        multiplier busy (0 without MUL_EN)
//   *_out                        EX/MEM register contents
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             wb_en,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             b,
  input  logic             s,
  input  logic             imm,
  input  logic [3:0]       alu_command,
  input  logic [3:0]       dest,
  input  logic [3:0]       status,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status_out,
  output logic             stall,
  output logic             wb_en_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [3:0]       dest_out
);

  logic [31:0] val2_s;
  logic [31:0] alu_b_s;
  logic        alu_cin_s;
  logic        is_arith_s;
  logic [31:0] logic_res_s;
  logic [32:0] sum_s;
  logic [31:0] alu_res_s;
  logic        flag_c_s;
  logic        flag_v_s;
  logic [3:0]  new_status_s;
  logic        stall_s;
  logic        mul_done_s;
  logic [31:0] mul_res_s;
  logic        unused_s;

  logic [3:0]  status_q, status_d;
  logic        wb_en_q, wb_en_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] alu_res_q, alu_res_d, val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;

  val2_gen u_val2_gen (
    .mem_rw        (mem_read | mem_write),
    .imm           (imm),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .val2          (val2_s)
  );

  assign branch_taken = b;
  assign branch_addr  = pc + {{6{signed_imm[23]}}, signed_imm, 2'b00};

  // ALU operand setup: subtraction is rn + ~val2 + carry-in, so SUB/SBC share the adder.
  always_comb begin
    alu_b_s     = val2_s;
    alu_cin_s   = 1'b0;
    is_arith_s  = 1'b0;
    logic_res_s = 32'd0;
    case (alu_command)
      CMD_ADD: is_arith_s = 1'b1;
      CMD_ADC: begin is_arith_s = 1'b1; alu_cin_s = status[ST_C]; end
      CMD_SUB: begin is_arith_s = 1'b1; alu_b_s = ~val2_s; alu_cin_s = 1'b1; end
      CMD_SBC: begin is_arith_s = 1'b1; alu_b_s = ~val2_s; alu_cin_s = status[ST_C]; end
      CMD_MOV: logic_res_s = val2_s;
      CMD_MVN: logic_res_s = ~val2_s;
      CMD_AND: logic_res_s = val_rn & val2_s;
      CMD_ORR: logic_res_s = val_rn | val2_s;
      CMD_EOR: logic_res_s = val_rn ^ val2_s;
      default: logic_res_s = 32'd0;
    endcase
  end

  assign sum_s = {1'b0, val_rn} + {1'b0, alu_b_s} + {32'd0, alu_cin_s};

  // Result and flags; carry out of the adder is "no borrow" for subtraction.
  // A finished multiply updates N and Z only, keeping the registered C and V.
  always_comb begin
    alu_res_s    = mul_done_s ? mul_res_s : (is_arith_s ? sum_s[31:0] : logic_res_s);
    flag_c_s     = mul_done_s ? status_q[ST_C] : (is_arith_s ? sum_s[32] : status[ST_C]);
    flag_v_s     = mul_done_s ? status_q[ST_V] :
                   (is_arith_s ? ((val_rn[31] == alu_b_s[31]) && (sum_s[31] != val_rn[31]))
                               : status[ST_V]);
    new_status_s = {alu_res_s[31], (alu_res_s == 32'd0), flag_c_s, flag_v_s};
  end

`ifdef MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  mul_state_e       mul_state_q, mul_state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [31:0]      prod_q, prod_d, mcand_q, mcand_d, mplier_q, mplier_d;

  // Multiplier FSM. The presentation cycle performs the first shift-add step
  // and already stalls, so IDLE + BUSY together stall for MUL_CYCLES cycles.
  always_comb begin
    mul_state_d = mul_state_q;
    mul_cnt_d   = mul_cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    stall_s     = 1'b0;
    case (mul_state_q)
      MUL_IDLE: begin
        if (alu_command == CMD_MUL) begin
          stall_s     = 1'b1;
          mul_state_d = MUL_BUSY;
          mul_cnt_d   = CNT_W'(1);
          prod_d      = val_rn[0] ? val2_s : 32'd0;
          mcand_d     = val2_s << 1;
          mplier_d    = val_rn >> 1;
        end else begin
          stall_s = 1'b0;
        end
      end
      MUL_BUSY: begin
        stall_s  = 1'b1;
        prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (mul_cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          mul_state_d = MUL_DONE;
        end else begin
          mul_cnt_d = mul_cnt_q + CNT_W'(1);
        end
      end
      MUL_DONE: mul_state_d = MUL_IDLE;
      default:  mul_state_d = MUL_IDLE;
    endcase
  end

  // Multiplier state; freeze holds the counter and partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state_q <= MUL_IDLE;
      mul_cnt_q   <= '0;
      prod_q      <= 32'd0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
    end else if (!freeze) begin
      mul_state_q <= mul_state_d;
      mul_cnt_q   <= mul_cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end else begin
      mul_state_q <= mul_state_q;
      mul_cnt_q   <= mul_cnt_q;
      prod_q      <= prod_q;
      mcand_q     <= mcand_q;
      mplier_q    <= mplier_q;
    end
  end

  assign mul_done_s = (mul_state_q == MUL_DONE);
  assign mul_res_s  = prod_q;
`else
  assign stall_s    = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_res_s  = 32'd0;
`endif

  // Status register and EX/MEM next values; a stall inserts a bubble by clearing control only.
  always_comb begin
    status_d    = status_q;
    wb_en_d     = wb_en_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_res_d   = alu_res_q;
    val_rm_d    = val_rm_q;
    dest_d      = dest_q;
    if (!freeze && !stall_s) begin
      status_d    = s ? new_status_s : status_q;
      wb_en_d     = wb_en;
      mem_read_d  = mem_read;
      mem_write_d = mem_write;
      alu_res_d   = alu_res_s;
      val_rm_d    = val_rm;
      dest_d      = dest;
    end else if (!freeze) begin
      wb_en_d     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // Status and EX/MEM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= 4'd0;
      wb_en_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_res_q   <= 32'd0;
      val_rm_q    <= 32'd0;
      dest_q      <= 4'd0;
    end else begin
      status_q    <= status_d;
      wb_en_q     <= wb_en_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_res_q   <= alu_res_d;
      val_rm_q    <= val_rm_d;
      dest_q      <= dest_d;
    end
  end

  assign stall         = stall_s;
  assign status_out    = status_q;
  assign wb_en_out     = wb_en_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign alu_res_out   = alu_res_q;
  assign val_rm_out    = val_rm_q;
  assign dest_out      = dest_q;

  // Only carry and overflow of the incoming NZCV feed the ALU.
  assign unused_s = ^{status[3:2], 32'(MUL_CYCLES)};

endmodule
